// File: rtl/vmst_refill_ctrl_pkg.sv
// Shared types and helpers for the merge-tree refill controller.
package vmst_refill_ctrl_pkg;
  localparam int W_LOG_DEF = 10;
  localparam int P_LOG_DEF = 3;
  localparam int DATW_DEF  = 64;
  localparam int KEYW_DEF  = 32;
  localparam int DATW_MAX  = 256;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  function automatic int blk_w(input int datw, input int plog);
    return datw << plog;
  endfunction

  // One sentinel record: key field all ones, payload bits zero.
  function automatic logic [DATW_MAX-1:0] sentinel_rec(input int keyw);
    logic [DATW_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < DATW_MAX; i++)
      if (i < keyw) r[i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/vmst_refill_ctrl_if.sv
// Memory request/response and tree-feed bus of the refill controller.
interface vmst_refill_ctrl_if #(
  parameter int W_LOG = 10,
  parameter int BLKW  = 512
);
  logic             REQ;
  logic [W_LOG-1:0] REQ_IDX;
  logic             REQ_RDY;
  logic             RSP;
  logic [W_LOG-1:0] RSP_IDX;
  logic [BLKW-1:0]  RSP_DAT;
  logic [BLKW-1:0]  DIN;
  logic             DINEN;
  logic [W_LOG-1:0] DIN_IDX;

  modport master (output REQ, REQ_IDX, DIN, DINEN, DIN_IDX,
                  input  REQ_RDY, RSP, RSP_IDX, RSP_DAT);
  modport slave  (input  REQ, REQ_IDX, DIN, DINEN, DIN_IDX,
                  output REQ_RDY, RSP, RSP_IDX, RSP_DAT);
endinterface

// File: rtl/vmst_refill_ctrl_way_scan.sv
// Round-robin way pointer plus per-way pending/remaining (and sentinel-sent) state.
module vmst_refill_ctrl_way_scan #(
  parameter int W_LOG = 10,
  parameter int CNTW  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                init,
  input  logic [CNTW-1:0]     run_blks,
  input  logic                active,
  input  logic [(1<<W_LOG)-1:0] emp,
  input  logic                req,
  input  logic                hs,
  input  logic                rsp_take,
  input  logic [W_LOG-1:0]    rsp_idx,
  input  logic                cap_ok,
  output logic [W_LOG-1:0]    ptr,
  output logic                elig,
  output logic                inj,
  output logic                all_done
);
  localparam int NW = 1 << W_LOG;

  logic [NW-1:0]   pend;
  logic [CNTW-1:0] rem [NW];
  logic            rem_zero;

  always_comb begin
    rem_zero = 1'b1;
    for (int i = 0; i < NW; i++)
      if (rem[i] != '0) rem_zero = 1'b0;
  end

  assign elig = active & ~req & emp[ptr] & ~pend[ptr] & (rem[ptr] != '0) & cap_ok;

`ifdef VMST_REFILL_SENTINEL_EN
  logic [NW-1:0] sent;
  // A response this cycle owns the output; the slot is still spent and retried next lap.
  assign inj      = active & ~req & ~rsp_take & emp[ptr] & ~pend[ptr] & (rem[ptr] == '0) & ~sent[ptr];
  assign all_done = rem_zero & (&sent);
`else
  assign inj      = 1'b0;
  assign all_done = rem_zero;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr  <= '0;
      pend <= '0;
      for (int i = 0; i < NW; i++) rem[i] <= '0;
`ifdef VMST_REFILL_SENTINEL_EN
      sent <= '0;
`endif
    end else if (init) begin
      ptr  <= '0;
      pend <= '0;
      for (int i = 0; i < NW; i++) rem[i] <= run_blks;
`ifdef VMST_REFILL_SENTINEL_EN
      sent <= '0;
`endif
    end else begin
      if (rsp_take) pend[rsp_idx] <= 1'b0;
      if (active) begin
        if (hs) begin
          pend[ptr] <= 1'b1;
          rem[ptr]  <= rem[ptr] - CNTW'(1);
          ptr       <= ptr + W_LOG'(1);
        end else if (!req && !elig) begin
          ptr <= ptr + W_LOG'(1);
        end
`ifdef VMST_REFILL_SENTINEL_EN
        if (inj) sent[ptr] <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: rtl/vmst_refill_ctrl.sv
// Refill controller feeding the virtual merge sorter tree; 1-cycle response-to-DIN latency.
// Optional sentinel injection for exhausted ways: define VMST_REFILL_SENTINEL_EN.
module vmst_refill_ctrl
  import vmst_refill_ctrl_pkg::*;
#(
  parameter int W_LOG = W_LOG_DEF,
  parameter int P_LOG = P_LOG_DEF,
  parameter int DATW  = DATW_DEF,
  parameter int KEYW  = KEYW_DEF,
  parameter int CNTW  = 16,
  parameter int OUTS  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INIT,
  input  logic [CNTW-1:0]       RUN_BLKS,
  input  logic [(1<<W_LOG)-1:0] EMP,
  vmst_refill_ctrl_if.master    bus,
  output logic                  DONE
);
  localparam int BLKW = blk_w(DATW, P_LOG);

`ifdef VMST_REFILL_SENTINEL_EN
  localparam logic [DATW_MAX-1:0] SENT_FULL = sentinel_rec(KEYW);
  localparam logic [DATW-1:0]     SENT_REC  = SENT_FULL[DATW-1:0];
  localparam logic [BLKW-1:0]     SENT_BLK  = {(1 << P_LOG){SENT_REC}};
`endif

  state_t           state;
  logic [3:0]       outs;
  logic [W_LOG-1:0] ptr;
  logic             elig, inj, all_done;
  logic             active, rsp_take, hs, cap_ok, fin_cond;

  assign active   = (state == ST_RUN);
  assign rsp_take = bus.RSP & (state != ST_IDLE);
  assign hs       = bus.REQ & bus.REQ_RDY;
  assign cap_ok   = (outs < 4'(OUTS));
  assign fin_cond = all_done & (outs == 4'd0) & ~bus.DINEN & ~bus.RSP & ~bus.REQ & ~inj;

  vmst_refill_ctrl_way_scan #(.W_LOG(W_LOG), .CNTW(CNTW)) u_scan (
    .CLK      (CLK),
    .RST      (RST),
    .init     (INIT),
    .run_blks (RUN_BLKS),
    .active   (active),
    .emp      (EMP),
    .req      (bus.REQ),
    .hs       (hs),
    .rsp_take (rsp_take),
    .rsp_idx  (bus.RSP_IDX),
    .cap_ok   (cap_ok),
    .ptr      (ptr),
    .elig     (elig),
    .inj      (inj),
    .all_done (all_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      outs        <= 4'd0;
      bus.REQ     <= 1'b0;
      bus.REQ_IDX <= '0;
      bus.DINEN   <= 1'b0;
      bus.DIN     <= '0;
      bus.DIN_IDX <= '0;
      DONE        <= 1'b0;
    end else begin
      bus.DINEN <= 1'b0;
      if (rsp_take) begin
        bus.DINEN   <= 1'b1;
        bus.DIN     <= bus.RSP_DAT;
        bus.DIN_IDX <= bus.RSP_IDX;
      end
`ifdef VMST_REFILL_SENTINEL_EN
      else if (inj) begin
        bus.DINEN   <= 1'b1;
        bus.DIN     <= SENT_BLK;
        bus.DIN_IDX <= ptr;
      end
`endif

      // A stray response with nothing outstanding must not wrap the counter.
      case ({hs, rsp_take && (outs != 4'd0)})
        2'b10:   outs <= outs + 4'd1;
        2'b01:   outs <= outs - 4'd1;
        default: outs <= outs;
      endcase

      if (INIT) begin
        state   <= ST_RUN;
        bus.REQ <= 1'b0;
        DONE    <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (hs) begin
              bus.REQ <= 1'b0;
            end else if (elig) begin
              bus.REQ     <= 1'b1;
              bus.REQ_IDX <= ptr;
            end
            if (fin_cond) begin
              state <= ST_FIN;
              DONE  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vmst_refill_ctrl.sv
// Directed bench for vmst_refill_ctrl with 4 ways, 128-bit blocks and 3 outstanding requests.
module tb_vmst_refill_ctrl;
  localparam int W_LOG = 2;
  localparam int P_LOG = 1;
  localparam int DATW  = 64;
  localparam int KEYW  = 32;
  localparam int CNTW  = 4;
  localparam int OUTS  = 3;
  localparam int BLKW  = DATW << P_LOG;
  localparam logic [BLKW-1:0] SENT = {2{32'h0, 32'hFFFF_FFFF}};
  localparam logic [BLKW-1:0] AB   = {16{8'hAB}};

  logic            CLK = 1'b0;
  logic            RST;
  logic            INIT;
  logic [CNTW-1:0] RUN_BLKS;
  logic [3:0]      EMP;
  logic            DONE;
  int checks = 0;
  int errors = 0;

  vmst_refill_ctrl_if #(.W_LOG(W_LOG), .BLKW(BLKW)) bus ();

  vmst_refill_ctrl #(.W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW),
                     .CNTW(CNTW), .OUTS(OUTS)) dut (
    .CLK(CLK), .RST(RST), .INIT(INIT), .RUN_BLKS(RUN_BLKS), .EMP(EMP),
    .bus(bus.master), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_init();
    INIT = 1'b1;
    tick();
    INIT = 1'b0;
  endtask

  function automatic logic [BLKW-1:0] blk_pat(input logic [1:0] i);
    return {16{8'hA0 | {6'b0, i}}};
  endfunction

  task automatic test_reset();
    checks++;
    if (bus.REQ !== 1'b0 || bus.REQ_IDX !== 2'd0 || bus.DINEN !== 1'b0 ||
        bus.DIN !== '0 || bus.DIN_IDX !== 2'd0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%b idx=%0d dinen=%b din=%h didx=%0d done=%b required all 0",
               bus.REQ, bus.REQ_IDX, bus.DINEN, bus.DIN, bus.DIN_IDX, DONE);
    end
  endtask

  task automatic test_basic();
    int n_req = 0, n_din = 0, n_sent = 0;
    int due [8];
    logic [1:0] widx [8];
    logic pv = 1'b0;
    logic [1:0] pidx = '0;
    logic [BLKW-1:0] pdat = '0;
    bit done_seen = 0;
    RUN_BLKS = 4'd1; EMP = 4'hF; bus.REQ_RDY = 1'b1;
    do_init();
    for (int c = 0; c < 300 && !done_seen; c++) begin
      if (pv) begin
        n_din++;
        checks++;
        if (bus.DINEN !== 1'b1 || bus.DIN_IDX !== pidx || bus.DIN !== pdat) begin
          errors++;
          $display("FAIL basic_fwd got dinen=%b idx=%0d din=%h required 1 idx=%0d din=%h",
                   bus.DINEN, bus.DIN_IDX, bus.DIN, pidx, pdat);
        end
      end else if (bus.DINEN === 1'b1) begin
`ifdef VMST_REFILL_SENTINEL_EN
        if (bus.DIN === SENT) n_sent++;
        else begin
          checks++; errors++;
          $display("FAIL basic_extra_din got din=%h required sentinel %h", bus.DIN, SENT);
        end
`else
        checks++; errors++;
        $display("FAIL basic_extra_din got dinen=1 idx=%0d required no block", bus.DIN_IDX);
`endif
      end
      pv = 1'b0;
      if (bus.REQ === 1'b1 && n_req < 8) begin
        checks++;
        if (bus.REQ_IDX !== 2'(n_req)) begin
          errors++;
          $display("FAIL basic_order got idx=%0d required %0d", bus.REQ_IDX, n_req);
        end
        due[n_req] = c + 3;
        widx[n_req] = bus.REQ_IDX;
        n_req++;
      end
      bus.RSP = 1'b0;
      for (int j = 0; j < n_req; j++)
        if (due[j] == c) begin
          bus.RSP = 1'b1; bus.RSP_IDX = widx[j]; bus.RSP_DAT = blk_pat(widx[j]);
          pv = 1'b1; pidx = widx[j]; pdat = blk_pat(widx[j]);
        end
      if (DONE === 1'b1) done_seen = 1;
      tick();
    end
    bus.RSP = 1'b0;
    checks++;
    if (!done_seen || n_req != 4 || n_din != 4) begin
      errors++;
      $display("FAIL basic_done got done=%0d reqs=%0d blocks=%0d required 1 4 4", done_seen, n_req, n_din);
    end
`ifdef VMST_REFILL_SENTINEL_EN
    checks++;
    if (n_sent != 4) begin
      errors++;
      $display("FAIL basic_sentinels got %0d required 4", n_sent);
    end
`endif
  endtask

  task automatic test_stall();
    bit got = 0;
    bit bad = 0;
    RUN_BLKS = 4'd2; EMP = 4'b0100; bus.REQ_RDY = 1'b0;
    do_init();
    checks++;
    if (DONE !== 1'b0) begin
      errors++; $display("FAIL init_clears_done got %b required 0", DONE);
    end
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.REQ === 1'b1) got = 1; else tick();
    end
    checks++;
    if (!got || bus.REQ_IDX !== 2'd2) begin
      errors++; $display("FAIL stall_first_req got req=%0d idx=%0d required 1 idx=2", got, bus.REQ_IDX);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.REQ !== 1'b1 || bus.REQ_IDX !== 2'd2) begin
        errors++; $display("FAIL stall_hold got req=%b idx=%0d required 1 idx=2", bus.REQ, bus.REQ_IDX);
      end
    end
    bus.REQ_RDY = 1'b1;
    tick();
    bus.REQ_RDY = 1'b0;
    checks++;
    if (bus.REQ !== 1'b0) begin
      errors++; $display("FAIL stall_drop got req=%b required 0", bus.REQ);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.REQ !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL pend_blocks got a request on a pending way required none");
    end
    bus.RSP = 1'b1; bus.RSP_IDX = 2'd2; bus.RSP_DAT = AB;
    tick();
    bus.RSP = 1'b0;
    checks++;
    if (bus.DINEN !== 1'b1 || bus.DIN_IDX !== 2'd2 || bus.DIN !== AB) begin
      errors++;
      $display("FAIL rsp_fwd got dinen=%b idx=%0d din=%h required 1 idx=2 din=%h",
               bus.DINEN, bus.DIN_IDX, bus.DIN, AB);
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.REQ === 1'b1) got = 1; else tick();
    end
    checks++;
    if (!got || bus.REQ_IDX !== 2'd2) begin
      errors++; $display("FAIL reelig got req=%0d idx=%0d required 1 idx=2", got, bus.REQ_IDX);
    end
    bus.REQ_RDY = 1'b1;
    tick();
    bus.REQ_RDY = 1'b0;
    bus.RSP = 1'b1; bus.RSP_IDX = 2'd2; bus.RSP_DAT = AB;
    tick();
    bus.RSP = 1'b0;
    tick();
  endtask

  task automatic test_outs();
    int n = 0;
    logic [1:0] first = '1;
    bit got = 0;
    RUN_BLKS = 4'd2; EMP = 4'hF; bus.REQ_RDY = 1'b1;
    do_init();
    for (int i = 0; i < 25; i++) begin
      if (bus.REQ === 1'b1) begin
        if (n == 0) first = bus.REQ_IDX;
        n++;
      end
      tick();
    end
    checks++;
    if (n != OUTS) begin
      errors++; $display("FAIL outs_limit got %0d handshakes required %0d", n, OUTS);
    end
    checks++;
    if (first !== 2'd0) begin
      errors++; $display("FAIL outs_first got idx=%0d required 0", first);
    end
    bus.RSP = 1'b1; bus.RSP_IDX = first; bus.RSP_DAT = blk_pat(first);
    tick();
    bus.RSP = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (bus.REQ === 1'b1) got = 1; else tick();
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL outs_resume got no request required one after a response");
    end
    tick();
  endtask

  task automatic test_rst_mid();
    RST = 1'b1;
    tick();
    checks++;
    if (bus.REQ !== 1'b0 || bus.DINEN !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got req=%b dinen=%b done=%b required 0 0 0", bus.REQ, bus.DINEN, DONE);
    end
    RST = 1'b0;
    bus.RSP = 1'b1; bus.RSP_IDX = 2'd1; bus.RSP_DAT = AB;
    tick();
    bus.RSP = 1'b0;
    checks++;
    if (bus.DINEN !== 1'b0) begin
      errors++; $display("FAIL late_rsp got dinen=%b required 0", bus.DINEN);
    end
    tick();
    checks++;
    if (bus.REQ !== 1'b0 || bus.DINEN !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got req=%b dinen=%b required 0 0", bus.REQ, bus.DINEN);
    end
  endtask

`ifdef VMST_REFILL_SENTINEL_EN
  task automatic test_sentinel();
    int n_inj = 0, n_req = 0, n_other = 0;
    bit pv = 0;
    RUN_BLKS = 4'd1; EMP = 4'b0010; bus.REQ_RDY = 1'b1;
    do_init();
    for (int c = 0; c < 40; c++) begin
      if (bus.DINEN === 1'b1) begin
        if (!pv && bus.DIN === SENT && bus.DIN_IDX === 2'd1) n_inj++;
        else if (!pv) n_other++;
      end
      pv = 0;
      bus.RSP = 1'b0;
      if (bus.REQ === 1'b1) begin
        n_req++;
        bus.RSP = 1'b1; bus.RSP_IDX = bus.REQ_IDX; bus.RSP_DAT = blk_pat(bus.REQ_IDX);
        pv = 1;
      end
      tick();
    end
    bus.RSP = 1'b0;
    checks++;
    if (n_inj != 1 || n_req != 1 || n_other != 0) begin
      errors++;
      $display("FAIL sentinel got inj=%0d reqs=%0d other=%0d required 1 1 0", n_inj, n_req, n_other);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; INIT = 1'b0; RUN_BLKS = '0; EMP = '0;
    bus.REQ_RDY = 1'b0; bus.RSP = 1'b0; bus.RSP_IDX = '0; bus.RSP_DAT = '0;
    tick(); tick();
    test_reset();
    RST = 1'b0;
    tick();
    test_basic();
    test_stall();
    test_outs();
    test_rst_mid();
`ifdef VMST_REFILL_SENTINEL_EN
    test_sentinel();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
